// File: rtl/mem_data_resp.sv
// Word-addressed data memory with a small store buffer: loads get priority on the
// single array port, and pending stores drain in idle cycles with load forwarding.
module mem_data_resp #(
    parameter int DEPTH = 256,
    parameter int WBUF  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writeAddress,
    input  logic [31:0] data,
    input  logic        writeEnabled,
    input  logic [31:0] readAddress,
    input  logic        readEnabled,
    output logic [31:0] out,
    output logic        outValid,
    output logic        busy,
    output logic        wrOverflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(WBUF);
    localparam int CW = $clog2(WBUF + 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] buf_addr_reg [WBUF];
    logic [31:0]   buf_data_reg [WBUF];
    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   out_reg;
    logic          out_valid_reg, overflow_reg;

    logic [AW-1:0] wr_word, rd_word;
    logic          accept, drain;
    logic [WBUF-1:0] hit_vec;
    logic [31:0]   hit_data [WBUF];
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          unused_addr_bits;

    // Upper address bits and byte offset alias onto the same word.
    assign wr_word = writeAddress[AW+1:2];
    assign rd_word = readAddress[AW+1:2];
    assign unused_addr_bits = ^{writeAddress[31:AW+2], writeAddress[1:0],
                                readAddress[31:AW+2], readAddress[1:0]};

    assign busy   = (count_reg == CW'(WBUF));
    assign accept = !reset && writeEnabled && !busy;
    assign drain  = !reset && !readEnabled && (count_reg != '0);

    // Match each occupied slot, numbered by age from head (gi = 0 is oldest).
    generate
        for (genvar gi = 0; gi < WBUF; gi++) begin : g_match
            logic [PW-1:0] slot;
            assign slot         = head_reg + PW'(gi);
            assign hit_vec[gi]  = (CW'(gi) < count_reg) && (buf_addr_reg[slot] == rd_word);
            assign hit_data[gi] = buf_data_reg[slot];
        end
    endgenerate

    // Later (younger) matches override earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WBUF; k++) begin
            if (hit_vec[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = hit_data[k];
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({accept, drain})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            mem[buf_addr_reg[head_reg]] <= buf_data_reg[head_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_addr_reg[tail_reg] <= wr_word;
            buf_data_reg[tail_reg] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (accept) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (drain) begin
                head_reg <= head_reg + PW'(1);
            end
            if (writeEnabled && busy) begin
                overflow_reg <= 1'b1;
            end
            if (readEnabled) begin
                out_reg       <= fwd_hit ? fwd_data : mem[rd_word];
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out        = out_reg;
    assign outValid   = out_valid_reg;
    assign wrOverflow = overflow_reg;
endmodule

// File: tb/tb_mem_data_resp.sv
// Bench for mem_data_resp: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_data_resp;
    localparam int DEPTH = 256;
    localparam int WBUF  = 4;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] writeAddress = '0;
    logic [31:0] data = '0;
    logic        writeEnabled = 1'b0;
    logic [31:0] readAddress = '0;
    logic        readEnabled = 1'b0;
    logic [31:0] out;
    logic        outValid, busy, wrOverflow;

    int checks = 0;
    int errors = 0;

    mem_data_resp #(.DEPTH(DEPTH), .WBUF(WBUF)) dut (
        .clk(clk), .reset(reset),
        .writeAddress(writeAddress), .data(data), .writeEnabled(writeEnabled),
        .readAddress(readAddress), .readEnabled(readEnabled),
        .out(out), .outValid(outValid), .busy(busy), .wrOverflow(wrOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] w;
        logic [31:0]   d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] m_out;
    logic        m_valid, m_ovf;
    bit          model_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer is a FIFO queue, array is a plain array.
    always begin
        logic [AW-1:0] rw;
        logic [31:0]   v;
        bit            full, dr;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_out    = '0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            model_ok = 1;
        end else begin
            full = (q.size() == WBUF);
            dr   = !readEnabled && (q.size() > 0);
            if (readEnabled) begin
                rw = readAddress[AW+1:2];
                v  = mem_m[rw];
                foreach (q[i]) if (q[i].w == rw) v = q[i].d;
                m_out   = v;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (dr) begin
                mem_m[q[0].w] = q[0].d;
                void'(q.pop_front());
            end
            if (writeEnabled) begin
                if (full) m_ovf = 1'b1;
                else q.push_back('{w: writeAddress[AW+1:2], d: data});
            end
        end
        #1;
        if (model_ok) begin
            chk("out", out, m_out);
            chk("outValid", {31'b0, outValid}, {31'b0, m_valid});
            chk("busy", {31'b0, busy}, {31'b0, q.size() == WBUF});
            chk("wrOverflow", {31'b0, wrOverflow}, {31'b0, m_ovf});
            $display("cyc t=%0t rst=%0b we=%0b wa=%08h d=%08h re=%0b ra=%08h -> out=%08h v=%0b busy=%0b ovf=%0b",
                     $time, reset, writeEnabled, writeAddress, data, readEnabled, readAddress,
                     out, outValid, busy, wrOverflow);
        end
    end

    task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] d,
                        input logic re, input logic [31:0] ra);
        reset        = 1'b0;
        writeEnabled = we;
        writeAddress = wa;
        data         = d;
        readEnabled  = re;
        readAddress  = ra;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Stores/loads asserted during reset must be ignored.
    task automatic pulse_reset(input int n);
        reset        = 1'b1;
        writeEnabled = 1'b1;
        writeAddress = 32'h0000_0080;
        data         = 32'hBAD0_BAD0;
        readEnabled  = 1'b1;
        readAddress  = 32'h0000_0080;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] wa, ra;
        logic        we, re;
        pulse_reset(2);
        chk("rst_out", out, 32'h0);
        chk("rst_valid", {31'b0, outValid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_ovf", {31'b0, wrOverflow}, 32'h0);

        for (int i = 0; i < DEPTH; i++) step(1, i * 4, 32'hC0DE_0000 | i, 0, 0);
        idle(4);

        // Store, wait, read back from the array.
        step(1, 32'h10, 32'hDEAD_BEEF, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 32'h10);
        chk("d1_out", out, 32'hDEAD_BEEF);
        chk("d1_valid", {31'b0, outValid}, 32'h1);
        idle(1);
        chk("d1_hold", out, 32'hDEAD_BEEF);
        chk("d1_novalid", {31'b0, outValid}, 32'h0);

        // Forwarding while reads block the drain.
        step(1, 32'h20, 32'h1111, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 32'h20);
            chk("d2_fwd", out, 32'h1111);
            chk("d2_notbusy", {31'b0, busy}, 32'h0);
        end
        idle(3);

        // Fill the buffer under continuous reads, then overflow.
        for (int i = 0; i < 4; i++) step(1, i * 4, 32'hAAAA_0000 + i, 1, 32'h100);
        chk("d3_busy", {31'b0, busy}, 32'h1);
        step(1, 32'h10, 32'h5555, 1, 32'h8);
        chk("d3_ovf", {31'b0, wrOverflow}, 32'h1);
        chk("d3_busy2", {31'b0, busy}, 32'h1);
        chk("d3_fwd", out, 32'hAAAA_0002);
        idle(5);
        chk("d3_drained", {31'b0, busy}, 32'h0);
        step(0, 0, 0, 1, 32'h10);
        chk("d3_ignored", out, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 32'h0);
        chk("d3_word0", out, 32'hAAAA_0000);

        // Youngest match wins; same-cycle store is not forwarded.
        step(1, 32'h40, 32'hA, 1, 32'h100);
        step(1, 32'h40, 32'hB, 1, 32'h100);
        step(0, 0, 0, 1, 32'h40);
        chk("d4_young", out, 32'hB);
        step(1, 32'h40, 32'hC, 1, 32'h40);
        chk("d4_samecyc", out, 32'hB);
        step(0, 0, 0, 1, 32'h40);
        chk("d4_after", out, 32'hC);

        // Aliasing above the array size.
        idle(4);
        step(0, 0, 0, 1, 32'h400);
        chk("d5_alias", out, 32'hAAAA_0000);

        // Reset discards buffered stores.
        step(1, 32'h80, 32'h1, 1, 32'h100);
        step(1, 32'h84, 32'h2, 1, 32'h100);
        step(1, 32'h88, 32'h3, 1, 32'h100);
        pulse_reset(1);
        chk("d6_busy", {31'b0, busy}, 32'h0);
        chk("d6_valid", {31'b0, outValid}, 32'h0);
        chk("d6_out", out, 32'h0);
        chk("d6_ovf", {31'b0, wrOverflow}, 32'h0);
        step(0, 0, 0, 1, 32'h80);
        chk("d6_rd80", out, 32'hC0DE_0020);
        step(0, 0, 0, 1, 32'h84);
        chk("d6_rd84", out, 32'hC0DE_0021);
        step(0, 0, 0, 1, 32'h88);
        chk("d6_rd88", out, 32'hC0DE_0022);

        // Randomized traffic over a small hot set with aliased upper bits.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                pulse_reset(1);
            end else begin
                we = ($urandom_range(0, 1) == 1);
                re = ($urandom_range(0, 99) < 60);
                wa = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                ra = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                step(we, wa, $urandom, re, ra);
            end
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_data_resp.md
MEM_DATA_RESP -- requirements
Module: mem_data_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in the data array (power of two).
REQ-002 SHALL have parameter WBUF, default 4, meaning number of write-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port writeAddress  input  32  byte address of store.
REQ-006 SHALL have port data  input  32  store data.
REQ-007 SHALL have port writeEnabled  input  1  store request, sampled every cycle.
REQ-008 SHALL have port readAddress  input  32  byte address of load.
REQ-009 SHALL have port readEnabled  input  1  load request, sampled every cycle.
REQ-010 SHALL have port out  output  32  load data, registered.
REQ-011 SHALL have port outValid  output  1  one-cycle pulse marking out as new load data.
REQ-012 SHALL have port busy  output  1  write buffer full; new stores not accepted.
REQ-013 SHALL have port wrOverflow  output  1  sticky flag: a store arrived while busy.

Function
REQ-014 SHALL address words by addr[log2(DEPTH)+1:2]; addr[1:0] and upper bits ignored (wrap-around aliasing).
REQ-015 SHALL accept a store into the write buffer tail when writeEnabled=1 and busy=0, in that cycle.
REQ-016 SHALL assert busy combinationally from registered count: busy = (count == WBUF).
REQ-017 SHALL ignore a store with writeEnabled=1 and busy=1 (no state change except wrOverflow set to 1).
REQ-018 SHALL use a single array port per cycle: read has priority; drain of the oldest buffer entry occurs only in cycles with readEnabled=0 and count>0.
REQ-019 SHALL on drain write the head entry into the array and advance head; count decrements by 1.
REQ-020 SHALL on same-cycle accept and drain keep count unchanged; full-state acceptance is decided on registered count, so no accept when count==WBUF even if draining.
REQ-021 SHALL on readEnabled=1 drive out, outValid=1 on the next rising edge (latency 1 cycle).
REQ-022 SHALL return the youngest buffer entry whose word address matches readAddress, else the array word.
REQ-023 SHALL search only entries present at the start of the cycle; a store accepted in the same cycle as a read to the same word is not forwarded (read returns prior value).
REQ-024 SHALL hold out unchanged and drive outValid=0 in cycles following readEnabled=0.
REQ-025 SHALL keep head/tail pointers modulo WBUF and count in range 0..WBUF at all times.
REQ-026 SHALL allow back-to-back reads every cycle; buffer does not drain while reads continue (busy may persist).

Reset
REQ-027 SHALL on reset=1 at a rising edge set count=0, head=0, tail=0, out=0, outValid=0, wrOverflow=0; busy therefore 0.
REQ-028 SHALL discard all pending buffered stores on reset, including mid-drain; array contents are not cleared.
REQ-029 SHALL ignore writeEnabled and readEnabled in any cycle where reset=1.

Verification
REQ-030 SHALL verify: store 0x0000_0010<=0xDEADBEEF, idle 2 cycles, read 0x10 -> next cycle out=0xDEADBEEF, outValid=1.
REQ-031 SHALL verify: store 0x20<=0x1111, then read 0x20 with readEnabled held high -> out=0x1111 from buffer while count stays 1.
REQ-032 SHALL verify: 4 stores to 0x0,0x4,0x8,0xC with readEnabled=1 every cycle -> busy=1 after 4th; 5th store ignored, wrOverflow=1, count stays 4.
REQ-033 SHALL verify: stores 0x40<=0xA then 0x40<=0xB, read 0x40 -> out=0xB (youngest); read in same cycle as a 3rd store 0x40<=0xC -> out=0xB.
REQ-034 SHALL verify: read 0x400 with DEPTH=256 -> returns word at 0x0 (aliasing).
REQ-035 SHALL verify: 3 stores buffered, reset pulsed 1 cycle -> busy=0, outValid=0, out=0, wrOverflow=0; subsequent read of those addresses returns pre-store array values.
